sramlike_axi_bridge: RTL and testbench



---
 rtl/sramlike_axi_bridge_pkg.sv | 29 ++
 rtl/sramlike_wstrb_gen.sv | 20 ++
 rtl/sramlike_axi_bridge.sv | 181 ++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge: FSM state codes,
// AXI field constants, default IDs and the latched-request record.
package sramlike_axi_bridge_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  localparam logic [3:0] DEF_INST_ID = 4'd0;
  localparam logic [3:0] DEF_DATA_ID = 4'd1;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef struct packed {
    logic        owner;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sramlike_wstrb_gen.sv
// Byte-lane strobe for a single-beat write from transfer size and address
// low bits; purely combinational.
module sramlike_wstrb_gen
  import sramlike_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Arbitrates instruction/data SRAM-like requests onto one AXI3 master port,
// single-beat, one transaction in flight; data side wins ties.
module sramlike_axi_bridge
  import sramlike_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = DEF_INST_ID,
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  logic [2:0] state;
  req_t       cur;
  logic       aw_done;
  logic       w_done;
  logic       grant_data;
  logic       grant_inst;
  logic       r_hs;
  logic       b_hs;
  logic       aw_fire;
  logic       w_fire;
  logic       wr_both;
  logic [3:0] cur_id;

  // Responses are single-ID, single-beat and always accepted, so these carry no information.
  logic unused_resp;
  assign unused_resp = &{1'b0, rid, rresp, rlast, bid, bresp};

  assign grant_data   = (state == ST_IDLE) && data_req;
  assign grant_inst   = (state == ST_IDLE) && inst_req && !data_req;
  assign data_addr_ok = grant_data;
  assign inst_addr_ok = grant_inst;

  assign r_hs    = (state == ST_RD_DATA) && rvalid;
  assign b_hs    = (state == ST_WR_RESP) && bvalid;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign wr_both = (aw_done || aw_fire) && (w_done || w_fire);

  assign cur_id  = (cur.owner == OWNER_DATA) ? DATA_ID : INST_ID;

  assign arvalid = (state == ST_RD_ADDR);
  assign rready  = (state == ST_RD_DATA);
  assign awvalid = (state == ST_WR_REQ) && !aw_done;
  assign wvalid  = (state == ST_WR_REQ) && !w_done;
  assign bready  = (state == ST_WR_RESP);

  assign arid    = cur_id;
  assign araddr  = cur.addr;
  assign arsize  = {1'b0, cur.size};
  assign arlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = cur_id;
  assign awaddr  = cur.addr;
  assign awsize  = {1'b0, cur.size};
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = cur_id;
  assign wdata   = cur.wdata;
  assign wlast   = 1'b1;

  sramlike_wstrb_gen u_wstrb (
    .size    (cur.size),
    .addr_lo (cur.addr[1:0]),
    .wstrb   (wstrb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur          <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
    end else begin
      inst_data_ok <= r_hs && (cur.owner == OWNER_INST);
      data_data_ok <= (r_hs && (cur.owner == OWNER_DATA)) || b_hs;
      case (state)
        ST_IDLE: begin
          if (grant_data) begin
            cur   <= '{owner: OWNER_DATA, size: data_size, addr: data_addr, wdata: data_wdata};
            state <= data_wr ? ST_WR_REQ : ST_RD_ADDR;
          end else if (grant_inst) begin
            cur   <= '{owner: OWNER_INST, size: SIZE_WORD, addr: inst_addr, wdata: 32'd0};
            state <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: if (arready) state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (rvalid) begin
            if (cur.owner == OWNER_DATA) data_rdata <= rdata;
            else                         inst_rdata <= rdata;
            state <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently; flags clear on exit so the next write starts fresh.
          if (wr_both) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WR_RESP;
          end else begin
            aw_done <= aw_done || aw_fire;
            w_done  <= w_done || w_fire;
          end
        end
        ST_WR_RESP: if (bvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Bench for sramlike_axi_bridge: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_sramlike_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [3:0]  arcache, awcache;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  sramlike_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction plus which of its handshakes have happened.
  bit          m_busy = 0, m_owner = 0, m_wr = 0, m_ar = 0, m_aw = 0, m_w = 0;
  bit          m_ok_i = 0, m_ok_d = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd_i = '0, m_rd_d = '0;
  logic [1:0]  m_size = '0;
  logic        e_iaok, e_daok, e_arv, e_rr, e_awv, e_wv, e_br;

  // Lanes covered by a naturally aligned transfer of 2**sz bytes containing lane a.
  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] a);
    int n    = 1 << sz;
    int base = (int'(a) / n) * n;
    logic [3:0] s = '0;
    for (int i = 0; i < n; i++) s[base + i] = 1'b1;
    return s;
  endfunction

  always @(negedge clk) begin
    e_daok = !m_busy && data_req;
    e_iaok = !m_busy && inst_req && !data_req;
    e_arv  = m_busy && !m_wr && !m_ar;
    e_rr   = m_busy && !m_wr && m_ar;
    e_awv  = m_busy && m_wr && !m_aw;
    e_wv   = m_busy && m_wr && !m_w;
    e_br   = m_busy && m_wr && m_aw && m_w;
    if (chk_on) begin
      check("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      check("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      check("arvalid", 32'(arvalid), 32'(e_arv));
      check("rready", 32'(rready), 32'(e_rr));
      check("awvalid", 32'(awvalid), 32'(e_awv));
      check("wvalid", 32'(wvalid), 32'(e_wv));
      check("bready", 32'(bready), 32'(e_br));
      check("inst_data_ok", 32'(inst_data_ok), 32'(m_ok_i));
      check("data_data_ok", 32'(data_data_ok), 32'(m_ok_d));
      check("inst_rdata", inst_rdata, m_rd_i);
      check("data_rdata", data_rdata, m_rd_d);
      check("ar_consts", {arlen, arburst, arlock, arcache, arprot}, {13'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
      check("aw_consts", {awlen, awburst, awlock, awcache, awprot, wlast}, {12'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
      if (e_arv) begin
        check("araddr", araddr, m_addr);
        check("arsize", 32'(arsize), 32'(m_size));
        check("arid", 32'(arid), 32'(m_owner));
      end
      if (e_awv) begin
        check("awaddr", awaddr, m_addr);
        check("awsize", 32'(awsize), 32'(m_size));
        check("awid", 32'(awid), 32'd1);
      end
      if (e_wv) begin
        check("wdata", wdata, m_wdata);
        check("wstrb", 32'(wstrb), 32'(strb_of(m_size, m_addr[1:0])));
        check("wid", 32'(wid), 32'd1);
      end
    end
    // Advance the model to what holds after the coming rising edge.
    if (rst) begin
      m_busy = 0; m_ar = 0; m_aw = 0; m_w = 0; m_ok_i = 0; m_ok_d = 0;
      m_rd_i = '0; m_rd_d = '0;
    end else begin
      m_ok_i = 0;
      m_ok_d = 0;
      if (e_rr && rvalid) begin
        if (m_owner) begin m_rd_d = rdata; m_ok_d = 1; end
        else begin m_rd_i = rdata; m_ok_i = 1; end
        m_busy = 0;
      end else if (e_br && bvalid) begin
        m_ok_d = 1;
        m_busy = 0;
      end else if (e_arv) begin
        if (arready) m_ar = 1;
      end else if (m_busy && m_wr && !(m_aw && m_w)) begin
        if (e_awv && awready) m_aw = 1;
        if (e_wv && wready) m_w = 1;
      end else if (e_daok || e_iaok) begin
        m_busy  = 1; m_ar = 0; m_aw = 0; m_w = 0;
        m_owner = e_daok;
        m_wr    = e_daok && data_wr;
        m_addr  = e_daok ? data_addr : inst_addr;
        m_size  = e_daok ? data_size : 2'b10;
        m_wdata = data_wdata;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [3:0] es, input string nm);
    cyc(); data_req = 1; data_wr = 1; data_size = sz; data_addr = a; data_wdata = wd;
    awready = 1; wready = 1;
    smp(); check({nm, "_aok"}, 32'(data_addr_ok), 32'd1);
    cyc(); data_req = 0; smp(); check({nm, "_strb"}, 32'(wstrb), 32'(es));
    cyc(); awready = 0; wready = 0; bvalid = 1; smp();
    cyc(); bvalid = 0; smp(); check({nm, "_ok"}, 32'(data_data_ok), 32'd1);
  endtask

  initial begin
    cyc(); chk_on = 1;
    cyc(); rst = 0;

    // Instruction read with an immediately responsive slave.
    cyc(); inst_req = 1; inst_addr = 32'hBFC00000; arready = 1; rvalid = 1; rdata = 32'h3C1D8000;
    smp(); check("t1_iaok", 32'(inst_addr_ok), 32'd1);
    cyc(); inst_req = 0;
    smp(); check("t1_arvalid", 32'(arvalid), 32'd1); check("t1_araddr", araddr, 32'hBFC00000);
    check("t1_arsize", 32'(arsize), 32'd2); check("t1_arid", 32'(arid), 32'd0);
    cyc(); smp(); check("t1_rready", 32'(rready), 32'd1);
    cyc(); smp(); check("t1_dok", 32'(inst_data_ok), 32'd1); check("t1_rdata", inst_rdata, 32'h3C1D8000);
    cyc(); arready = 0; rvalid = 0; smp(); check("t1_dok_drop", 32'(inst_data_ok), 32'd0);

    // Byte write, W accepted three cycles after AW, late B.
    cyc(); data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h80000003; data_wdata = 32'hAB;
    smp(); check("t2_daok", 32'(data_addr_ok), 32'd1);
    cyc(); data_req = 0; awready = 1; wready = 0;
    smp(); check("t2_awsize", 32'(awsize), 32'd0); check("t2_wstrb", 32'(wstrb), 32'h8);
    cyc(); awready = 0; smp(); check("t2_awv", 32'(awvalid), 32'd0); check("t2_wv", 32'(wvalid), 32'd1);
    cyc(); smp();
    cyc(); wready = 1; smp(); check("t2_wv_hold", 32'(wvalid), 32'd1);
    cyc(); wready = 0; smp(); check("t2_bready", 32'(bready), 32'd1); check("t2_no_ok", 32'(data_data_ok), 32'd0);
    cyc(); smp();
    cyc(); bvalid = 1; smp(); check("t2_no_ok_b", 32'(data_data_ok), 32'd0);
    cyc(); bvalid = 0; smp(); check("t2_ok", 32'(data_data_ok), 32'd1);
    cyc(); smp(); check("t2_ok_drop", 32'(data_data_ok), 32'd0);

    // Simultaneous requests: data first, inst granted alongside data_ok.
    cyc(); inst_req = 1; inst_addr = 32'hBFC00010; data_req = 1; data_wr = 0; data_size = 2'b10;
    data_addr = 32'h80001000; arready = 1; rvalid = 1; rdata = 32'h11223344;
    smp(); check("t3_daok", 32'(data_addr_ok), 32'd1); check("t3_iaok0", 32'(inst_addr_ok), 32'd0);
    cyc(); data_req = 0; smp(); check("t3_arid", 32'(arid), 32'd1);
    cyc(); smp(); check("t3_iaok_busy", 32'(inst_addr_ok), 32'd0);
    cyc(); rdata = 32'h55667788;
    smp(); check("t3_dok", 32'(data_data_ok), 32'd1); check("t3_iaok", 32'(inst_addr_ok), 32'd1);
    check("t3_drdata", data_rdata, 32'h11223344);
    cyc(); inst_req = 0; smp(); check("t3_araddr", araddr, 32'hBFC00010);
    cyc(); smp();
    cyc(); arready = 0; rvalid = 0;
    smp(); check("t3_iok", 32'(inst_data_ok), 32'd1); check("t3_irdata", inst_rdata, 32'h55667788);

    do_write(32'h80000002, 2'b01, 32'hBEEF0000, 4'b1100, "t4_half_hi");
    do_write(32'h80000000, 2'b01, 32'h0000BEEF, 4'b0011, "t4_half_lo");
    do_write(32'h80000004, 2'b10, 32'h12345678, 4'b1111, "t4_word");

    // Read with rvalid held off for five cycles.
    cyc(); data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h80002004; arready = 1; rvalid = 0;
    smp();
    cyc(); data_req = 0; smp();
    for (int i = 0; i < 5; i++) begin
      cyc(); arready = 0;
      smp(); check("t5_rready", 32'(rready), 32'd1); check("t5_no_ok", 32'(data_data_ok), 32'd0);
    end
    cyc(); rvalid = 1; rdata = 32'hCAFEF00D; smp();
    cyc(); rvalid = 0; rdata = '0;
    smp(); check("t5_ok", 32'(data_data_ok), 32'd1); check("t5_rdata", data_rdata, 32'hCAFEF00D);
    cyc(); smp(); check("t5_ok_drop", 32'(data_data_ok), 32'd0); check("t5_rdata_hold", data_rdata, 32'hCAFEF00D);

    // Reset while waiting in the read-data phase.
    cyc(); inst_req = 1; inst_addr = 32'hBFC00100; arready = 1; smp();
    cyc(); inst_req = 0; smp();
    cyc(); arready = 0; rvalid = 1; rdata = 32'hDEADBEEF; rst = 1; smp(); check("t6_rready", 32'(rready), 32'd1);
    cyc(); rst = 0; rvalid = 0;
    smp(); check("t6_arv", 32'(arvalid), 32'd0); check("t6_rr", 32'(rready), 32'd0);
    check("t6_iok", 32'(inst_data_ok), 32'd0); check("t6_irdata", inst_rdata, 32'd0);
    cyc(); inst_req = 1; inst_addr = 32'hBFC00200; arready = 1; rvalid = 1; rdata = 32'h24020001;
    smp(); check("t6_iaok", 32'(inst_addr_ok), 32'd1);
    cyc(); inst_req = 0; smp();
    cyc(); smp();
    cyc(); smp(); check("t6_iok2", 32'(inst_data_ok), 32'd1); check("t6_irdata2", inst_rdata, 32'h24020001);
    cyc(); arready = 0; rvalid = 0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst        = ($urandom_range(0, 299) == 0);
      inst_req   = 1'($urandom_range(0, 1));
      inst_addr  = $urandom;
      data_req   = ($urandom_range(0, 2) == 0);
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wdata = $urandom;
      arready    = 1'($urandom_range(0, 1));
      rvalid     = ($urandom_range(0, 2) == 0);
      rdata      = $urandom;
      rid        = 4'($urandom);
      rresp      = 2'($urandom);
      rlast      = 1'($urandom_range(0, 1));
      awready    = 1'($urandom_range(0, 1));
      wready     = 1'($urandom_range(0, 1));
      bvalid     = ($urandom_range(0, 2) == 0);
      bid        = 4'($urandom);
      bresp      = 2'($urandom);
    end
    cyc();
    inst_req = 0; data_req = 0; arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rst = 0;
    smp();
    cyc();
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
